// File: rtl/excpt_ctrl.sv
// CP0-lite exception/interrupt controller: Status/Cause/EPC plus the
// fetch redirect sequencer for SYSCALL, external interrupts and ERET.
module excpt_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
    parameter int          INT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] int_req,
    input  logic             syscall,
    input  logic             eret,
    input  logic [31:0]      id_pc,
    input  logic             id_valid,
    input  logic             cp0_we,
    input  logic [4:0]       cp0_waddr,
    input  logic [31:0]      cp0_wdata,
    input  logic [4:0]       cp0_raddr,
    output logic [31:0]      cp0_rdata,
    output logic             excpt,
    output logic [31:0]      ejpc,
    output logic             flush,
    output logic [31:0]      epc_out
);

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        HANDLER
    } state_e;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [INT_W-1:0]   im_q, im_d;
    logic [INT_W-1:0]   ip_q;
    logic [4:0]         exc_q, exc_d;
    logic [31:0]        epc_q, epc_d;
    logic               excpt_q, excpt_d;
    logic [31:0]        ejpc_q, ejpc_d;

    logic               take;
    logic               do_eret;
    logic               do_sys;
    logic               do_irq;
    logic               unused_wdata;

    assign unused_wdata = ^{cp0_wdata[31:16], cp0_wdata[9:2]};

    assign take    = (state_q != FLUSH) && id_valid;
    assign do_eret = take && eret;
    assign do_sys  = take && !eret && syscall && !exl_q;
    assign do_irq  = take && !eret && !(syscall && !exl_q)
                   && ie_q && !exl_q && (|(ip_q & im_q));

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        ie_d    = ie_q;
        exl_d   = exl_q;
        im_d    = im_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        excpt_d = 1'b0;
        ejpc_d  = ejpc_q;

        // MTC0 lands first so a same-cycle exception can override it
        if (cp0_we && cp0_waddr == REG_STATUS) begin
            ie_d  = cp0_wdata[0];
            exl_d = cp0_wdata[1];
            im_d  = cp0_wdata[10 +: INT_W];
        end
        if (cp0_we && cp0_waddr == REG_EPC) begin
            epc_d = cp0_wdata;
        end

        if (state_q == FLUSH) begin
            // second FLUSH cycle drops the stale fetch, then resume
            if (!excpt_q) begin
                state_d = ret_q;
            end
        end else begin
            unique case (1'b1)
                do_eret: begin
                    ejpc_d  = epc_q;
                    exl_d   = 1'b0;
                    excpt_d = 1'b1;
                    state_d = FLUSH;
                    ret_d   = IDLE;
                end
                do_sys: begin
                    epc_d   = id_pc;
                    exc_d   = EXC_SYS;
                    exl_d   = 1'b1;
                    ejpc_d  = HANDLER_ADDR;
                    excpt_d = 1'b1;
                    state_d = FLUSH;
                    ret_d   = HANDLER;
                end
                do_irq: begin
                    epc_d   = id_pc;
                    exc_d   = EXC_INT;
                    exl_d   = 1'b1;
                    ejpc_d  = HANDLER_ADDR;
                    excpt_d = 1'b1;
                    state_d = FLUSH;
                    ret_d   = HANDLER;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            im_q    <= '0;
            ip_q    <= '0;
            exc_q   <= '0;
            epc_q   <= '0;
            excpt_q <= 1'b0;
            ejpc_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            im_q    <= im_d;
            ip_q    <= int_req;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
            excpt_q <= excpt_d;
            ejpc_q  <= ejpc_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            REG_STATUS: begin
                cp0_rdata[0]          = ie_q;
                cp0_rdata[1]          = exl_q;
                cp0_rdata[10 +: INT_W] = im_q;
            end
            REG_CAUSE: begin
                cp0_rdata[6:2]         = exc_q;
                cp0_rdata[10 +: INT_W] = ip_q;
            end
            REG_EPC: cp0_rdata = epc_q;
            default: cp0_rdata = '0;
        endcase
    end

    assign excpt   = excpt_q;
    assign ejpc    = ejpc_q;
    assign flush   = (state_q == FLUSH);
    assign epc_out = epc_q;

endmodule

// File: tb/tb_excpt_ctrl.sv
// Bench for excpt_ctrl: directed scenarios plus random traffic, all
// checked against a cycle-count reference model of the CP0 rules.
module tb_excpt_ctrl;

    localparam logic [31:0] HADDR = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_req;
    logic        syscall;
    logic        eret;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        excpt;
    logic [31:0] ejpc;
    logic        flush;
    logic [31:0] epc_out;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit          m_ie, m_exl;
    logic [5:0]  m_im, m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_ejpc;
    bit          m_excpt;
    int          m_blk;

    always #5 clk = ~clk;

    excpt_ctrl #(.HANDLER_ADDR(HADDR), .INT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .int_req   (int_req),
        .syscall   (syscall),
        .eret      (eret),
        .id_pc     (id_pc),
        .id_valid  (id_valid),
        .cp0_we    (cp0_we),
        .cp0_waddr (cp0_waddr),
        .cp0_wdata (cp0_wdata),
        .cp0_raddr (cp0_raddr),
        .cp0_rdata (cp0_rdata),
        .excpt     (excpt),
        .ejpc      (ejpc),
        .flush     (flush),
        .epc_out   (epc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_ip, 3'b000, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0; m_exc = 0;
        m_epc = 0; m_ejpc = 0; m_excpt = 0; m_blk = 0;
    endtask

    // One clock of the architectural rules, from the current inputs
    task automatic model_step();
        bit          ie0  = m_ie;
        bit          exl0 = m_exl;
        logic [5:0]  ip0  = m_ip;
        logic [5:0]  im0  = m_im;
        logic [31:0] epc0 = m_epc;
        m_excpt = 0;
        if (rst) begin
            model_reset();
            return;
        end
        m_ip = int_req;
        if (cp0_we && cp0_waddr == 5'd12) begin
            m_ie  = cp0_wdata[0];
            m_exl = cp0_wdata[1];
            m_im  = cp0_wdata[15:10];
        end
        if (cp0_we && cp0_waddr == 5'd14) m_epc = cp0_wdata;
        if (m_blk == 0 && id_valid) begin
            if (eret) begin
                m_ejpc = epc0; m_exl = 0; m_excpt = 1; m_blk = 2;
            end else if (syscall && !exl0) begin
                m_epc = id_pc; m_exc = 8; m_exl = 1;
                m_ejpc = HADDR; m_excpt = 1; m_blk = 2;
            end else if (ie0 && !exl0 && (ip0 & im0) != 0) begin
                m_epc = id_pc; m_exc = 0; m_exl = 1;
                m_ejpc = HADDR; m_excpt = 1; m_blk = 2;
            end
        end else if (m_blk > 0) begin
            m_blk--;
        end
    endtask

    task automatic cycle();
        #1;
        chk("rdata", cp0_rdata, mread(cp0_raddr));
        model_step();
        @(posedge clk);
        #1;
        chk("excpt", {31'b0, excpt}, {31'b0, m_excpt});
        chk("flush", {31'b0, flush}, {31'b0, m_blk > 0});
        if (m_excpt) chk("ejpc", ejpc, m_ejpc);
        chk("epc_out", epc_out, m_epc);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a,
                           input logic [31:0] exp);
        cp0_raddr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic clr();
        rst = 0; int_req = 0; syscall = 0; eret = 0; id_pc = 0;
        id_valid = 0; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
        cp0_raddr = 5'd12;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
        cycle();
        cp0_we = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();

        // reset state
        do_reset();
        chk_reg("rst_status", 5'd12, 32'h0);
        chk_reg("rst_cause", 5'd13, 32'h0);
        chk_reg("rst_epc", 5'd14, 32'h0);
        chk("rst_excpt", {31'b0, excpt}, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);

        // syscall entry
        id_pc = 32'h100; syscall = 1; id_valid = 1;
        cycle();
        chk("sys_excpt", {31'b0, excpt}, 32'h1);
        chk("sys_ejpc", ejpc, 32'h40);
        chk("sys_flush1", {31'b0, flush}, 32'h1);
        syscall = 0; id_valid = 0;
        chk_reg("sys_epc", 5'd14, 32'h100);
        chk_reg("sys_cause", 5'd13, 32'h20);
        chk_reg("sys_status", 5'd12, 32'h2);
        cycle();
        chk("sys_flush2", {31'b0, flush}, 32'h1);
        chk("sys_pulse", {31'b0, excpt}, 32'h0);
        cycle();
        chk("sys_flush3", {31'b0, flush}, 32'h0);

        // eret back from handler
        eret = 1; id_valid = 1;
        cycle();
        chk("eret_excpt", {31'b0, excpt}, 32'h1);
        chk("eret_ejpc", ejpc, 32'h100);
        eret = 0; id_valid = 0;
        chk_reg("eret_status", 5'd12, 32'h0);
        cycle();
        cycle();
        chk("eret_idle", {31'b0, flush}, 32'h0);

        // interrupt latency K+2
        do_reset();
        wr(5'd12, 32'h0401);
        id_valid = 1; id_pc = 32'h200; int_req = 6'h01;
        cycle();
        chk("irq_k1", {31'b0, excpt}, 32'h0);
        cycle();
        chk("irq_k2", {31'b0, excpt}, 32'h1);
        chk("irq_ejpc", ejpc, 32'h40);
        int_req = 0; id_valid = 0;
        chk_reg("irq_epc", 5'd14, 32'h200);
        chk_reg("irq_cause", 5'd13, 32'h400);
        cycle();
        cycle();

        // masked by IM=0
        do_reset();
        wr(5'd12, 32'h0001);
        id_valid = 1; id_pc = 32'h204; int_req = 6'h01;
        repeat (4) cycle();
        chk("im0_none", {31'b0, excpt}, 32'h0);

        // masked by EXL=1, then eret wins over the pending interrupt
        do_reset();
        wr(5'd14, 32'h300);
        wr(5'd12, 32'h0403);
        id_valid = 1; id_pc = 32'h208; int_req = 6'h01;
        repeat (3) cycle();
        chk("exl_none", {31'b0, excpt}, 32'h0);
        eret = 1;
        cycle();
        chk("eret_win", ejpc, 32'h300);
        chk_reg("eret_win_cause", 5'd13, 32'h400);
        eret = 0;
        repeat (4) cycle();
        clr();
        repeat (3) cycle();

        // syscall and interrupt together
        do_reset();
        wr(5'd12, 32'h0401);
        int_req = 6'h01;
        repeat (2) cycle();
        syscall = 1; id_valid = 1; id_pc = 32'h500;
        cycle();
        chk("sysirq_excpt", {31'b0, excpt}, 32'h1);
        chk_reg("sysirq_cause", 5'd13, 32'h420);
        clr();
        repeat (3) cycle();

        // id_valid=0 defers entry
        do_reset();
        wr(5'd12, 32'h0401);
        int_req = 6'h01;
        repeat (5) cycle();
        chk("hold_none", {31'b0, excpt}, 32'h0);
        id_valid = 1; id_pc = 32'h600;
        cycle();
        chk("hold_take", {31'b0, excpt}, 32'h1);
        chk_reg("hold_epc", 5'd14, 32'h600);
        clr();
        repeat (3) cycle();

        // reset during the excpt cycle
        do_reset();
        syscall = 1; id_valid = 1; id_pc = 32'h700;
        cycle();
        chk("rstmid_pre", {31'b0, excpt}, 32'h1);
        syscall = 0; id_valid = 0; rst = 1;
        cycle();
        rst = 0;
        chk("rstmid_excpt", {31'b0, excpt}, 32'h0);
        chk("rstmid_flush", {31'b0, flush}, 32'h0);
        chk_reg("rstmid_status", 5'd12, 32'h0);
        chk_reg("rstmid_cause", 5'd13, 32'h0);
        chk_reg("rstmid_epc", 5'd14, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom % 64) == 0;
            int_req  = ($urandom % 3 == 0) ? 6'($urandom) : 6'h0;
            syscall  = ($urandom % 6) == 0;
            eret     = ($urandom % 9) == 0;
            id_valid = ($urandom % 4) != 0;
            id_pc    = $urandom & 32'hFFFF_FFFC;
            cp0_we   = ($urandom % 5) == 0;
            case ($urandom % 4)
                0: cp0_waddr = 5'd12;
                1: cp0_waddr = 5'd13;
                2: cp0_waddr = 5'd14;
                default: cp0_waddr = 5'($urandom);
            endcase
            cp0_wdata = $urandom;
            case ($urandom % 4)
                0: cp0_raddr = 5'd12;
                1: cp0_raddr = 5'd13;
                2: cp0_raddr = 5'd14;
                default: cp0_raddr = 5'($urandom);
            endcase
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
